// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with debounce, frame checking and FWFT byte FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            ps2_clk_i,
    input  logic                            ps2_data_i,
    input  logic                            rx_en_i,
    input  logic                            rd_i,
    input  logic                            clr_err_i,
    output logic [7:0]                      data_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            byte_ok_o,
    output logic                            parity_err_o,
    output logic                            frame_err_o,
    output logic                            overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CYC+1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t                r_state;
    logic [1:0]            r_clk_sync, r_dat_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_filt_q;
    logic [3:0]            r_bitcnt;
    logic [9:0]            r_shift;
    logic [TW-1:0]         r_tmo;
    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr, r_rd;
    logic [CW-1:0]         r_count;

    logic w_filt_nxt, w_fall, w_data, w_par_ok, w_stop_ok, w_good, w_push, w_pop, w_tmo;

    assign w_filt_nxt = &r_filt ? 1'b1 : ~|r_filt ? 1'b0 : r_filt_q;
    assign w_fall     = r_filt_q & ~w_filt_nxt;
    assign w_data     = r_dat_sync[1];
    assign w_par_ok   = ^r_shift[8:0];
    assign w_stop_ok  = r_shift[9];
    assign w_good     = (r_state == CHECK) & w_par_ok & w_stop_ok;
    assign w_pop      = rd_i & ~empty_o;
    // A full FIFO still accepts the byte when the head is popped in the same cycle.
    assign w_push     = w_good & (~full_o | rd_i);
    assign w_tmo      = (r_state == SHIFT) & ~w_fall & (r_tmo == TW'(TIMEOUT_CYC-1));

    assign data_o    = r_mem[r_rd];
    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == CW'(FIFO_DEPTH));
    assign count_o   = r_count;
    assign byte_ok_o = w_push;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt     <= '1;
            r_filt_q   <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
            r_dat_sync <= {r_dat_sync[0], ps2_data_i};
            r_filt     <= {r_filt[FILTER_LEN-2:0], r_clk_sync[1]};
            r_filt_q   <= w_filt_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_tmo        <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            parity_err_o <= ((r_state == CHECK) & ~w_par_ok) | (parity_err_o & ~clr_err_i);
            frame_err_o  <= ((r_state == IDLE) & w_fall & rx_en_i & w_data) | w_tmo |
                            ((r_state == CHECK) & ~w_stop_ok) | (frame_err_o & ~clr_err_i);
            overflow_o   <= (w_good & full_o & ~rd_i) | (overflow_o & ~clr_err_i);
            case (r_state)
                IDLE: if (w_fall && rx_en_i && !w_data) begin
                    r_bitcnt <= '0;
                    r_tmo    <= '0;
                    r_state  <= SHIFT;
                end
                SHIFT: if (w_fall) begin
                    r_shift  <= {w_data, r_shift[9:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    r_tmo    <= '0;
                    r_state  <= (r_bitcnt == 4'd9) ? CHECK : SHIFT;
                end else if (w_tmo) begin
                    r_shift <= '0;
                    r_state <= IDLE;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_mem[r_wr] <= r_shift[7:0];
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule
